micro_sequencer: RTL and testbench

//  Next-micro-address controller for the microprogrammed control unit.

---
 rtl/micro_seq_pkg.sv | 47 ++++
 rtl/micro_seq_if.sv | 35 +++
 rtl/micro_ret_stack.sv | 48 ++++
 rtl/micro_sequencer.sv | 157 +++++++++++++++
 tb/tb_micro_sequencer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared types for the micro-sequencer.
//   next_sel_e   - next-address source select carried by the microword
//   seq_state_e  - sequencer FSM states
//   disp_res_t   - result of an opcode dispatch lookup {hit, addr}
//   dispatch_lookup() - opcode -> micro-address map; a miss sends the
//                       sequencer to its fault entry
package micro_seq_pkg;

    typedef enum logic [1:0] {
        SEL_INC      = 2'b00,
        SEL_JUMP     = 2'b01,
        SEL_DISPATCH = 2'b10,
        SEL_COND     = 2'b11
    } next_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    localparam int DISP_OPC_W  = 6;
    localparam int DISP_ADDR_W = 6;

    typedef struct packed {
        logic                   hit;
        logic [DISP_ADDR_W-1:0] addr;
    } disp_res_t;

    // Dispatch map. Entry points are the first microword of each
    // instruction's microroutine.
    function automatic disp_res_t dispatch_lookup(input logic [DISP_OPC_W-1:0] opc);
        disp_res_t r;
        r.hit  = 1'b1;
        r.addr = '0;
        case (opc)
            6'h00:   r.addr = 6'd16;
            6'h01:   r.addr = 6'd20;
            6'h10:   r.addr = 6'd40;
            6'h23:   r.addr = 6'd12;
            default: r.hit  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/micro_seq_if.sv
// micro_seq_if: microword / control-store address bundle.
//   master: drives start, stall, halt, next_sel, next_addr, cond, opcode,
//           ucall, uret; observes uaddr, uaddr_vld, busy, fault
//   slave : the sequencer side (directions reversed)
interface micro_seq_if #(
    parameter int UADDR_W = 6,
    parameter int OPC_W   = 6
);
    import micro_seq_pkg::*;

    logic               start;
    logic               stall;
    logic               halt;
    next_sel_e          next_sel;
    logic [UADDR_W-1:0] next_addr;
    logic               cond;
    logic [OPC_W-1:0]   opcode;
    logic               ucall;
    logic               uret;
    logic [UADDR_W-1:0] uaddr;
    logic               uaddr_vld;
    logic               busy;
    logic               fault;

    modport master (
        output start, stall, halt, next_sel, next_addr, cond, opcode, ucall, uret,
        input  uaddr, uaddr_vld, busy, fault
    );

    modport slave (
        input  start, stall, halt, next_sel, next_addr, cond, opcode, ucall, uret,
        output uaddr, uaddr_vld, busy, fault
    );

endinterface

// File: rtl/micro_ret_stack.sv
// micro_ret_stack: LIFO of return micro-addresses for microcode calls.
// Only compiled when MICRO_SEQ_CALL_EN is defined.
//   clk, rst_n    - clock, async active-low reset (clears pointer)
//   clr           - synchronous pointer clear (new microprogram)
//   push/push_data- store a return address (ignored when full)
//   pop           - discard the top entry (ignored when empty)
//   top           - most recently pushed entry
//   full, empty   - occupancy flags
`ifdef MICRO_SEQ_CALL_EN
module micro_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_dec;
    logic [W-1:0]  mem [DEPTH];

    assign full    = (ptr == PW'(DEPTH));
    assign empty   = (ptr == '0);
    assign ptr_dec = ptr - PW'(1);
    assign top     = mem[ptr_dec[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ptr <= '0;
        else if (clr)            ptr <= '0;
        else if (push && !full)  ptr <= ptr + PW'(1);
        else if (pop && !empty)  ptr <= ptr_dec;
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (!clr && push && !full) mem[ptr[AW-1:0]] <= push_data;
    end
endmodule
`endif

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-micro-address controller for the control store.
//   clk, rst_n - clock, async active-low reset
//   bus        - micro_seq_if.slave: microword fields in, uaddr/uaddr_vld/
//                busy/fault out (uaddr and fault are registered)
// Optional feature macro: MICRO_SEQ_CALL_EN adds a STACK_DEPTH-entry return
// stack for ucall/uret. Without it ucall acts as a jump and uret is ignored.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int UADDR_W     = 6,
    parameter int OPC_W       = 6,
    parameter int RESET_UADDR = 0,
    parameter int FAULT_UADDR = 63,
    parameter int STACK_DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    micro_seq_if.slave bus
);
    seq_state_e         state, state_nxt;
    logic [UADDR_W-1:0] uaddr, uaddr_nxt, uaddr_inc, sel_addr;
    logic               fault, fault_nxt, sel_fault;
    logic               start_acc, advance;
    disp_res_t          disp;

    // A start is only honoured when no microprogram is running.
    assign start_acc = (state == ST_IDLE || state == ST_HALT) && bus.start;
    // Leaving STALL evaluates the current microword in the same cycle.
    assign advance   = (state == ST_RUN || state == ST_STALL) && !bus.stall && !bus.halt;
    assign uaddr_inc = uaddr + UADDR_W'(1);
    assign disp      = dispatch_lookup(DISP_OPC_W'(bus.opcode));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state (stall outranks halt)
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: if (bus.start) state_nxt = ST_RUN;
            ST_RUN, ST_STALL: begin
                if (bus.stall)     state_nxt = ST_STALL;
                else if (bus.halt) state_nxt = ST_HALT;
                else               state_nxt = ST_RUN;
            end
            default:           state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.uaddr_vld = (state == ST_RUN || state == ST_STALL);
        bus.busy      = (state == ST_RUN || state == ST_STALL);
    end

    // Plain next_sel decode
    always_comb begin
        sel_addr  = uaddr_inc;
        sel_fault = 1'b0;
        case (bus.next_sel)
            SEL_INC:  sel_addr = uaddr_inc;
            SEL_JUMP: sel_addr = bus.next_addr;
            SEL_DISPATCH: begin
                sel_addr  = disp.hit ? UADDR_W'(disp.addr) : UADDR_W'(FAULT_UADDR);
                sel_fault = !disp.hit;
            end
            SEL_COND: sel_addr = bus.cond ? bus.next_addr : uaddr_inc;
            default:  sel_addr = uaddr_inc;
        endcase
    end

`ifdef MICRO_SEQ_CALL_EN
    logic               push, pop, stk_full, stk_empty;
    logic [UADDR_W-1:0] stk_top;

    micro_ret_stack #(.DEPTH(STACK_DEPTH), .W(UADDR_W)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .push      (push),
        .pop       (pop),
        .push_data (uaddr_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Priority once advancing: uret > ucall > next_sel.
    always_comb begin
        uaddr_nxt = uaddr;
        fault_nxt = fault;
        push      = 1'b0;
        pop       = 1'b0;
        if (start_acc) begin
            uaddr_nxt = UADDR_W'(RESET_UADDR);
            fault_nxt = 1'b0;
        end else if (advance) begin
            if (bus.uret) begin
                if (stk_empty) begin
                    uaddr_nxt = UADDR_W'(FAULT_UADDR);
                    fault_nxt = 1'b1;
                end else begin
                    uaddr_nxt = stk_top;
                    pop       = 1'b1;
                end
            end else if (bus.ucall) begin
                if (stk_full) begin
                    uaddr_nxt = UADDR_W'(FAULT_UADDR);
                    fault_nxt = 1'b1;
                end else begin
                    uaddr_nxt = bus.next_addr;
                    push      = 1'b1;
                end
            end else begin
                uaddr_nxt = sel_addr;
                fault_nxt = fault | sel_fault;
            end
        end
    end
`else
    logic unused_uret;
    assign unused_uret = bus.uret;

    always_comb begin
        uaddr_nxt = uaddr;
        fault_nxt = fault;
        if (start_acc) begin
            uaddr_nxt = UADDR_W'(RESET_UADDR);
            fault_nxt = 1'b0;
        end else if (advance) begin
            if (bus.ucall) begin
                uaddr_nxt = bus.next_addr;
            end else begin
                uaddr_nxt = sel_addr;
                fault_nxt = fault | sel_fault;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uaddr <= '0;
            fault <= 1'b0;
        end else begin
            uaddr <= uaddr_nxt;
            fault <= fault_nxt;
        end
    end

    assign bus.uaddr = uaddr;
    assign bus.fault = fault;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: table-driven bench with an expected-result queue.
// Each table row is one microword cycle plus the expected registered
// outputs {uaddr, uaddr_vld, busy, fault} after the following clock edge.
module tb_micro_sequencer;
    import micro_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    micro_seq_if #(.UADDR_W(6), .OPC_W(6)) bus ();

    micro_sequencer #(
        .UADDR_W(6), .OPC_W(6), .RESET_UADDR(0), .FAULT_UADDR(63), .STACK_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ctl = {start, stall, halt, ucall, uret}
    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [1:0] sel;
        logic [5:0] na;
        logic       cond;
        logic [5:0] op;
        logic [8:0] exp;   // {uaddr, vld, busy, fault}
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic vec_t mk(input string n, input logic [4:0] c, input logic [1:0] s,
                                input logic [5:0] a, input logic cd, input logic [5:0] o,
                                input logic [5:0] eu, input logic ev, input logic eb,
                                input logic ef);
        vec_t v;
        v.name = n; v.ctl = c; v.sel = s; v.na = a; v.cond = cd; v.op = o;
        v.exp  = {eu, ev, eb, ef};
        return v;
    endfunction

    task automatic check(input string n, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got uaddr=%0d vld=%b busy=%b fault=%b, want uaddr=%0d vld=%b busy=%b fault=%b",
                     n, act[8:3], act[2], act[1], act[0], exp[8:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.uaddr, bus.uaddr_vld, bus.busy, bus.fault};
    endfunction

    task automatic step(input vec_t v);
        logic [8:0] e;
        {bus.start, bus.stall, bus.halt, bus.ucall, bus.uret} = v.ctl;
        bus.next_sel  = next_sel_e'(v.sel);
        bus.next_addr = v.na;
        bus.cond      = v.cond;
        bus.opcode    = v.op;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(v.name, outs(), e);
    endtask

    initial begin
        bus.start = 0; bus.stall = 0; bus.halt = 0; bus.ucall = 0; bus.uret = 0;
        bus.next_sel = SEL_INC; bus.next_addr = '0; bus.cond = 0; bus.opcode = '0;

        //        name            ctl       sel  na  cd op     uaddr vld busy flt
        tbl.push_back(mk("start",        5'b10000, 2'd0, 0,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("inc1",         5'b00000, 2'd0, 0,  0, 0,     1, 1, 1, 0));
        tbl.push_back(mk("inc2",         5'b00000, 2'd0, 0,  0, 0,     2, 1, 1, 0));
        tbl.push_back(mk("inc3",         5'b00000, 2'd0, 0,  0, 0,     3, 1, 1, 0));
        tbl.push_back(mk("jump5",        5'b00000, 2'd1, 5,  0, 0,     5, 1, 1, 0));
        tbl.push_back(mk("cond_taken",   5'b00000, 2'd3, 20, 1, 0,     20, 1, 1, 0));
        tbl.push_back(mk("jump5b",       5'b00000, 2'd1, 5,  0, 0,     5, 1, 1, 0));
        tbl.push_back(mk("cond_not",     5'b00000, 2'd3, 20, 0, 0,     6, 1, 1, 0));
        tbl.push_back(mk("disp_hit",     5'b00000, 2'd2, 0,  0, 6'h23, 12, 1, 1, 0));
        tbl.push_back(mk("disp_h01",     5'b00000, 2'd2, 0,  0, 6'h01, 20, 1, 1, 0));
        tbl.push_back(mk("disp_miss",    5'b00000, 2'd2, 0,  0, 6'h3F, 63, 1, 1, 1));
        tbl.push_back(mk("inc_wrap",     5'b00000, 2'd0, 0,  0, 0,     0, 1, 1, 1));
        tbl.push_back(mk("start_in_run", 5'b10000, 2'd0, 0,  0, 0,     1, 1, 1, 1));
        tbl.push_back(mk("halt",         5'b00100, 2'd0, 0,  0, 0,     1, 0, 0, 1));
        tbl.push_back(mk("restart",      5'b10000, 2'd0, 0,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("stall1",       5'b01000, 2'd1, 9,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("stall2",       5'b01000, 2'd1, 9,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("stall3",       5'b01000, 2'd1, 9,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("unstall_j9",   5'b00000, 2'd1, 9,  0, 0,     9, 1, 1, 0));
        tbl.push_back(mk("stall_halt",   5'b01100, 2'd1, 4,  0, 0,     9, 1, 1, 0));
        tbl.push_back(mk("halt_after",   5'b00100, 2'd1, 4,  0, 0,     9, 0, 0, 0));
        tbl.push_back(mk("start3",       5'b10000, 2'd0, 0,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("jump7",        5'b00000, 2'd1, 7,  0, 0,     7, 1, 1, 0));
        tbl.push_back(mk("halt_at7",     5'b00100, 2'd0, 0,  0, 0,     7, 0, 0, 0));
        tbl.push_back(mk("halt_hold",    5'b00000, 2'd0, 0,  0, 0,     7, 0, 0, 0));
        tbl.push_back(mk("start4",       5'b10000, 2'd0, 0,  0, 0,     0, 1, 1, 0));
`ifdef MICRO_SEQ_CALL_EN
        tbl.push_back(mk("jump4",        5'b00000, 2'd1, 4,  0, 0,     4, 1, 1, 0));
        tbl.push_back(mk("call30",       5'b00010, 2'd0, 30, 0, 0,     30, 1, 1, 0));
        tbl.push_back(mk("ret5",         5'b00001, 2'd0, 0,  0, 0,     5, 1, 1, 0));
        tbl.push_back(mk("ret_empty",    5'b00001, 2'd0, 0,  0, 0,     63, 1, 1, 1));
        tbl.push_back(mk("halt_s",       5'b00100, 2'd0, 0,  0, 0,     63, 0, 0, 1));
        tbl.push_back(mk("start_s",      5'b10000, 2'd0, 0,  0, 0,     0, 1, 1, 0));
        tbl.push_back(mk("call10",       5'b00010, 2'd0, 10, 0, 0,     10, 1, 1, 0));
        tbl.push_back(mk("call11",       5'b00010, 2'd0, 11, 0, 0,     11, 1, 1, 0));
        tbl.push_back(mk("call12",       5'b00010, 2'd0, 12, 0, 0,     12, 1, 1, 0));
        tbl.push_back(mk("call13",       5'b00010, 2'd0, 13, 0, 0,     13, 1, 1, 0));
        tbl.push_back(mk("call_full",    5'b00010, 2'd0, 14, 0, 0,     63, 1, 1, 1));
        tbl.push_back(mk("ret_top13",    5'b00001, 2'd0, 0,  0, 0,     13, 1, 1, 1));
        tbl.push_back(mk("ret_over_call",5'b00011, 2'd0, 40, 0, 0,     12, 1, 1, 1));
`else
        tbl.push_back(mk("ucall_jump",   5'b00010, 2'd0, 30, 0, 0,     30, 1, 1, 0));
        tbl.push_back(mk("uret_ignored", 5'b00001, 2'd0, 0,  0, 0,     31, 1, 1, 0));
        tbl.push_back(mk("uret_jump",    5'b00001, 2'd1, 17, 0, 0,     17, 1, 1, 0));
`endif
        tbl.push_back(mk("pre_reset",    5'b00000, 2'd1, 33, 0, 0,     33, 1, 1, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 9'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_start", outs(), 9'b0);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Asynchronous reset mid-run: outputs clear before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 9'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_reset", outs(), 9'b0);
        bus.start = 1'b0;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
